// File: rtl/pdm_cic_stereo.sv
// Stereo PDM microphone front end: PDM clock divider, per-channel capture on opposite clock
// phases, and an N-stage CIC decimator per channel with a valid/ready PCM output.
module pdm_cic_stereo #(
    parameter int unsigned CLK_DIV   = 32,
    parameter int unsigned DEC_LOG2  = 6,
    parameter int unsigned CIC_ORDER = 4,
    parameter int unsigned OUT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             stereo_i,
    output logic             pdm_clk_o,
    output logic             pdm_lrsel_o,
    input  logic             pdm_data_i,
    output logic [OUT_W-1:0] left_o,
    output logic [OUT_W-1:0] right_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             ovf_o,
    input  logic             clr_ovf_i
);

    localparam int unsigned ACC_W = CIC_ORDER * DEC_LOG2 + 2;
    localparam int unsigned HALF  = CLK_DIV / 2;
    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [1:0]          sync;
    logic                en_q, stereo_mode;
    logic                strb_l, strb_r, frame, frame_end, load;
    logic [DEC_LOG2-1:0] dec_cnt;
    logic [ACC_W-1:0]    x;
    logic [ACC_W-1:0]    int_l [CIC_ORDER];
    logic [ACC_W-1:0]    int_r [CIC_ORDER];
    logic [ACC_W-1:0]    int_l_nxt [CIC_ORDER];
    logic [ACC_W-1:0]    int_r_nxt [CIC_ORDER];
    logic [ACC_W-1:0]    pipe_l [CIC_ORDER+1];
    logic [ACC_W-1:0]    pipe_r [CIC_ORDER+1];
    logic [ACC_W-1:0]    dly_l [CIC_ORDER];
    logic [ACC_W-1:0]    dly_r [CIC_ORDER];
    logic [CIC_ORDER:0]  pipe_v;
    logic                unused_lsb;

    assign pdm_lrsel_o = 1'b0;

    always_comb begin
        cnt_nxt = '0;
        if (en_i && cnt != CNT_W'(CLK_DIV - 1)) cnt_nxt = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt         <= '0;
            pdm_clk_o   <= 1'b0;
            sync        <= '0;
            en_q        <= 1'b0;
            stereo_mode <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            pdm_clk_o <= en_i && (cnt_nxt < CNT_W'(HALF));
            sync      <= {sync[0], pdm_data_i};
            en_q      <= en_i;
            if (en_i && !en_q) stereo_mode <= stereo_i;
        end
    end

    // Synchroniser delay is 2 cycles, so these strobes see the pin just before each clock edge.
    assign strb_l    = en_i && (cnt == CNT_W'(HALF + 1));
    assign strb_r    = en_i && stereo_mode && (cnt == CNT_W'(1));
    assign frame     = stereo_mode ? strb_r : strb_l;
    assign frame_end = frame && (dec_cnt == '1);
    assign x         = sync[1] ? ACC_W'(1) : '1;
    assign load      = pipe_v[CIC_ORDER];

    always_comb begin
        int_l_nxt[0] = int_l[0] + x;
        int_r_nxt[0] = int_r[0] + x;
        for (int k = 1; k < CIC_ORDER; k++) begin
            int_l_nxt[k] = int_l[k] + int_l[k-1];
            int_r_nxt[k] = int_r[k] + int_r[k-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < CIC_ORDER; k++) begin
                int_l[k] <= '0;
                int_r[k] <= '0;
                dly_l[k] <= '0;
                dly_r[k] <= '0;
            end
            for (int k = 0; k <= CIC_ORDER; k++) begin
                pipe_l[k] <= '0;
                pipe_r[k] <= '0;
            end
            pipe_v  <= '0;
            dec_cnt <= '0;
        end else if (!en_i) begin
            for (int k = 0; k < CIC_ORDER; k++) begin
                int_l[k] <= '0;
                int_r[k] <= '0;
                dly_l[k] <= '0;
                dly_r[k] <= '0;
            end
            for (int k = 0; k <= CIC_ORDER; k++) begin
                pipe_l[k] <= '0;
                pipe_r[k] <= '0;
            end
            pipe_v  <= '0;
            dec_cnt <= '0;
        end else begin
            if (strb_l) for (int k = 0; k < CIC_ORDER; k++) int_l[k] <= int_l_nxt[k];
            if (strb_r) for (int k = 0; k < CIC_ORDER; k++) int_r[k] <= int_r_nxt[k];
            if (frame) dec_cnt <= dec_cnt + DEC_LOG2'(1);
            pipe_v <= {pipe_v[CIC_ORDER-1:0], frame_end};
            // Take the freshly updated value for whichever channel strobes in this cycle.
            if (frame_end) begin
                pipe_l[0] <= strb_l ? int_l_nxt[CIC_ORDER-1] : int_l[CIC_ORDER-1];
                pipe_r[0] <= strb_r ? int_r_nxt[CIC_ORDER-1] : int_r[CIC_ORDER-1];
            end
            for (int k = 0; k < CIC_ORDER; k++) begin
                if (pipe_v[k]) begin
                    pipe_l[k+1] <= pipe_l[k] - dly_l[k];
                    pipe_r[k+1] <= pipe_r[k] - dly_r[k];
                    dly_l[k]    <= pipe_l[k];
                    dly_r[k]    <= pipe_r[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            left_o  <= '0;
            right_o <= '0;
            valid_o <= 1'b0;
        end else if (!en_i) begin
            valid_o <= 1'b0;
        end else if (load) begin
            left_o  <= pipe_l[CIC_ORDER][ACC_W-1 -: OUT_W];
            right_o <= stereo_mode ? pipe_r[CIC_ORDER][ACC_W-1 -: OUT_W]
                                   : pipe_l[CIC_ORDER][ACC_W-1 -: OUT_W];
            valid_o <= 1'b1;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_o <= 1'b0;
        end else if (en_i && load && valid_o && !ready_i) begin
            ovf_o <= 1'b1;
        end else if (clr_ovf_i) begin
            ovf_o <= 1'b0;
        end
    end

    assign unused_lsb = ^{pipe_l[CIC_ORDER], pipe_r[CIC_ORDER]};

endmodule
